// File: rtl/parity_mem_pkg.sv
// -----------------------------------------------------------------------------
// parity_mem_pkg
// Shared types and helpers for the parity-protected memory controller.
//   state_t      : controller FSM states (IDLE, CLEAR)
//   even_parity  : XOR-reduction of a data word (zero-extend narrower words)
//   depth_of     : number of locations for a given address width
// -----------------------------------------------------------------------------
package parity_mem_pkg;

    // Widest data word even_parity accepts; callers zero-extend to this width.
    localparam int PARITY_MAX_W = 256;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
        return ^data;
    endfunction

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/parity_mem_array.sv
// -----------------------------------------------------------------------------
// parity_mem_array
// Plain synchronous RAM, DEPTH x (DATA_W+1), one write port and one registered
// read port. No reset on storage or read register. Reading and writing the
// same address in one cycle returns the old content.
// Ports:
//   clk     : rising-edge clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write word
//   i_re    : read enable (read register holds when low)
//   i_raddr : read address
//   o_rdata : registered read word
// -----------------------------------------------------------------------------
module parity_mem_array
    import parity_mem_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W:0]   i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W:0]   o_rdata
);

    localparam int DEPTH = depth_of(ADDR_W);

    logic [DATA_W:0] r_mem [DEPTH];
    logic [DATA_W:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/parity_mem_ctrl.sv
// -----------------------------------------------------------------------------
// parity_mem_ctrl
// Parity-protected single-port memory with a built-in array clear engine.
// Each word is stored as {even parity, data}; parity is re-checked on every
// read and mismatches are counted in a saturating counter.
// Optional build macro: PARITY_ERR_INJECT_EN adds err_inject, which inverts
// the stored parity bit on writes.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   clear          : pulse, restart array clear (ignored while busy)
//   write, read    : access requests (ignored while busy)
//   address        : access address
//   data_in        : write data
//   err_inject     : (PARITY_ERR_INJECT_EN only) corrupt stored parity
//   data_out       : {stored parity, stored data}, holds between reads
//   rd_valid       : one-cycle strobe, data_out carries a new read
//   parity_err     : with rd_valid, stored parity mismatched
//   err_count      : saturating parity error count
//   busy           : clear engine running
//
// state | meaning
// IDLE  | serving read/write/clear requests
// CLEAR | writing zero word at ptr each cycle, ptr 0..DEPTH-1
// -----------------------------------------------------------------------------
module parity_mem_ctrl
    import parity_mem_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              write,
    input  logic              read,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
`ifdef PARITY_ERR_INJECT_EN
    input  logic              err_inject,
`endif
    output logic [DATA_W:0]   data_out,
    output logic              rd_valid,
    output logic              parity_err,
    output logic [CNT_W-1:0]  err_count,
    output logic              busy
);

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_next;
    logic              r_rd_valid;
    logic              r_has_data;
    logic [CNT_W-1:0]  r_err_count;

    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W:0]   w_wdata;
    logic              w_re;
    logic              w_cnt_clr;
    logic              w_par;
    logic [DATA_W:0]   w_ram_q;

`ifdef PARITY_ERR_INJECT_EN
    assign w_par = even_parity(PARITY_MAX_W'(data_in)) ^ err_inject;
`else
    assign w_par = even_parity(PARITY_MAX_W'(data_in));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_next_state;
            r_ptr   <= w_ptr_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_ptr_next   = r_ptr;
        w_we         = 1'b0;
        w_waddr      = address;
        w_wdata      = {w_par, data_in};
        w_re         = 1'b0;
        w_cnt_clr    = 1'b0;
        case (r_state)
            CLEAR: begin
                w_we       = 1'b1;
                w_waddr    = r_ptr;
                w_wdata    = '0;
                w_ptr_next = r_ptr + ADDR_W'(1);
                if (&r_ptr) begin
                    w_next_state = IDLE;
                end
            end
            IDLE: begin
                // clear takes priority; a same-cycle read/write is dropped
                if (clear) begin
                    w_next_state = CLEAR;
                    w_ptr_next   = '0;
                    w_cnt_clr    = 1'b1;
                end else begin
                    w_we = write;
                    w_re = read;
                end
            end
            default: begin
                w_next_state = CLEAR;
                w_ptr_next   = '0;
            end
        endcase
    end

    parity_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_re),
        .i_raddr (address),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid  <= 1'b0;
            r_has_data  <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_rd_valid <= w_re;
            if (w_re) begin
                r_has_data <= 1'b1;
            end
            if (w_cnt_clr) begin
                r_err_count <= '0;
            end else if (parity_err && !(&r_err_count)) begin
                r_err_count <= r_err_count + CNT_W'(1);
            end
        end
    end

    // The RAM read register has no reset; mask it until the first read
    // after reset so data_out comes up as zero.
    assign data_out   = r_has_data ? w_ram_q : '0;
    assign rd_valid   = r_rd_valid;
    assign parity_err = r_rd_valid & (^data_out);
    assign err_count  = r_err_count;
    assign busy       = (r_state == CLEAR);

endmodule

// File: tb/tb_parity_mem_ctrl.sv
module tb_parity_mem_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clear = 1'b0;
    logic              write = 1'b0;
    logic              read = 1'b0;
    logic [ADDR_W-1:0] address = '0;
    logic [DATA_W-1:0] data_in = '0;
`ifdef PARITY_ERR_INJECT_EN
    logic              err_inject = 1'b0;
`endif
    logic [DATA_W:0]   data_out;
    logic              rd_valid;
    logic              parity_err;
    logic [CNT_W-1:0]  err_count;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;

    // expected read response: {parity_err, data_out}
    logic [DATA_W+1:0] q_exp[$];

    always #5 clk = ~clk;

    parity_mem_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .write      (write),
        .read       (read),
        .address    (address),
        .data_in    (data_in),
`ifdef PARITY_ERR_INJECT_EN
        .err_inject (err_inject),
`endif
        .data_out   (data_out),
        .rd_valid   (rd_valid),
        .parity_err (parity_err),
        .err_count  (err_count),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every rd_valid pops one expected response.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (q_exp.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rd_valid: got data_out %0h expected no read", data_out);
            end else begin
                logic [DATA_W+1:0] e;
                e = q_exp.pop_front();
                check("rd_data", 32'(data_out), 32'(e[DATA_W:0]));
                check("rd_parity_err", 32'(parity_err), 32'(e[DATA_W+1]));
            end
        end
    end

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        write   = 1'b1;
        address = a;
        data_in = d;
        @(negedge clk);
        write = 1'b0;
    endtask

    // Issue a read, push its expectation, and check it arrives one cycle later.
    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [DATA_W:0] exp_word,
                           input logic exp_perr);
        read    = 1'b1;
        address = a;
        q_exp.push_back({exp_perr, exp_word});
        @(negedge clk);
        read = 1'b0;
        check("rd_latency", 32'(rd_valid), 32'd1);
    endtask

    // Count busy samples starting at the current negedge (bounded).
    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_data_out"}, 32'(data_out), 32'd0);
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        check({tag, "_parity_err"}, 32'(parity_err), 32'd0);
        check({tag, "_err_count"}, 32'(err_count), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // 1: reset values, clear length, reads during and after busy
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            read    = (n == 5);
            address = 4'd9;
            n++;
            @(negedge clk);
        end
        read = 1'b0;
        check("busy_cycles_after_reset", 32'(n), 32'd16);
        do_read(4'd9, 9'h000, 1'b0);

        // 2: write then read back
        do_write(4'd3, 8'hA5);
        do_write(4'd5, 8'h07);
        do_read(4'd3, 9'h0A5, 1'b0);
        do_read(4'd5, 9'h107, 1'b0);

        // 3: same-cycle read and write returns old content
        write   = 1'b1;
        read    = 1'b1;
        address = 4'd5;
        data_in = 8'h01;
        q_exp.push_back({1'b0, 9'h107});
        @(negedge clk);
        write = 1'b0;
        read  = 1'b0;
        check("rw_same_cycle_valid", 32'(rd_valid), 32'd1);
        do_read(4'd5, 9'h101, 1'b0);
        check("err_count_clean", 32'(err_count), 32'd0);

`ifdef PARITY_ERR_INJECT_EN
        // 4: injected parity errors, saturation, clear resets counter
        err_inject = 1'b1;
        do_write(4'd2, 8'h3C);
        err_inject = 1'b0;
        do_read(4'd2, 9'h13C, 1'b1);
        @(negedge clk);
        check("err_count_one", 32'(err_count), 32'd1);
        for (int i = 0; i < 4; i++) begin
            do_read(4'd2, 9'h13C, 1'b1);
        end
        @(negedge clk);
        check("err_count_saturated", 32'(err_count), 32'd3);
        pulse_clear();
        check("err_count_cleared", 32'(err_count), 32'd0);
        count_busy(n);
        check("busy_cycles_inject_clear", 32'(n), 32'd16);
`endif

        // 5: reset in the middle of a clear
        do_write(4'd15, 8'h55);
        do_read(4'd15, 9'h055, 1'b0);
        pulse_clear();
        repeat (6) @(negedge clk);
        check("mid_clear_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_values("mid_clear_rst");
        @(negedge clk);
        rst = 1'b0;
        count_busy(n);
        check("busy_cycles_after_mid_rst", 32'(n), 32'd16);
        do_read(4'd15, 9'h000, 1'b0);

        // 6: clear wins over same-cycle write and read
        clear   = 1'b1;
        write   = 1'b1;
        read    = 1'b1;
        address = 4'd4;
        data_in = 8'hFF;
        @(negedge clk);
        clear = 1'b0;
        write = 1'b0;
        read  = 1'b0;
        check("clear_wins_busy", 32'(busy), 32'd1);
        count_busy(n);
        check("busy_cycles_clear_write", 32'(n), 32'd16);
        do_read(4'd4, 9'h000, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(q_exp.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
